vga_controller: RTL and testbench



---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_timing.sv | 58 +++++
 rtl/vga_controller.sv | 90 +++++++++
 tb/tb_vga_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Default 800x600@60 Hz (40 MHz pixel clock) timing set and pattern helpers
// shared by the VGA timing generator and test-pattern top.
package vga_pkg;

   localparam int DEF_H_ACTIVE  = 800;
   localparam int DEF_H_FP      = 40;
   localparam int DEF_H_SYNC    = 128;
   localparam int DEF_H_BP      = 88;
   localparam int DEF_V_ACTIVE  = 600;
   localparam int DEF_V_FP      = 1;
   localparam int DEF_V_SYNC    = 4;
   localparam int DEF_V_BP      = 23;
   localparam int DEF_BAR_WIDTH = 100;

   localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int DEF_H_W     = $clog2(DEF_H_TOTAL);
   localparam int DEF_V_W     = $clog2(DEF_V_TOTAL);

   localparam logic [2:0] RGB_BLACK = 3'b000;

   // Bars run white..black left to right, i.e. the colour is the bar index inverted.
   function automatic logic [2:0] bar_color(input logic [2:0] bar);
      return 3'd7 - bar;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with sync-window and active-area decode.
// Decode outputs are combinational; the top registers them.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic clk,
   input  logic reset,
   output logic o_line_end,
   output logic o_hsync_on,
   output logic o_vsync_on,
   output logic o_active
);

   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_W          = $clog2(H_TOTAL);
   localparam int V_W          = $clog2(V_TOTAL);
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   logic [H_W-1:0] r_hcount;
   logic [V_W-1:0] r_vcount;
   logic           w_hwrap;
   logic           w_vwrap;

   assign w_hwrap = (r_hcount == H_W'(H_TOTAL - 1));
   assign w_vwrap = (r_vcount == V_W'(V_TOTAL - 1));

   // Vertical advances only on the line wrap, so the frame restarts at (0,0).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hcount <= '0;
         r_vcount <= '0;
      end else begin
         r_hcount <= w_hwrap ? '0 : r_hcount + H_W'(1);
         if (w_hwrap) begin
            r_vcount <= w_vwrap ? '0 : r_vcount + V_W'(1);
         end
      end
   end

   assign o_line_end = w_hwrap;
   assign o_hsync_on = (r_hcount >= H_W'(H_SYNC_START)) && (r_hcount < H_W'(H_SYNC_END));
   assign o_vsync_on = (r_vcount >= V_W'(V_SYNC_START)) && (r_vcount < V_W'(V_SYNC_END));
   assign o_active   = (r_hcount < H_W'(H_ACTIVE)) && (r_vcount < V_W'(V_ACTIVE));

endmodule

// File: rtl/vga_controller.sv
// VGA timing generator with an eight-bar colour test pattern; every pin is
// driven from a register one cycle behind the raster counters.
module vga_controller
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE  = DEF_H_ACTIVE,
   parameter int   H_FP      = DEF_H_FP,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BP      = DEF_H_BP,
   parameter int   V_ACTIVE  = DEF_V_ACTIVE,
   parameter int   V_FP      = DEF_V_FP,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BP      = DEF_V_BP,
   parameter logic SYNC_POL  = 1'b1,
   parameter int   BAR_WIDTH = DEF_BAR_WIDTH
) (
   input  logic clk,
   input  logic reset,
   output logic hsync,
   output logic vsync,
   output logic red,
   output logic grn,
   output logic blu
);

   localparam int             BAR_W    = $clog2(BAR_WIDTH + 1);
   localparam logic [BAR_W-1:0] BAR_LAST = BAR_W'(BAR_WIDTH - 1);

   logic             w_line_end;
   logic             w_hsync_on;
   logic             w_vsync_on;
   logic             w_active;
   logic [BAR_W-1:0] r_bar_left;
   logic [2:0]       r_bar;
   logic             r_hsync;
   logic             r_vsync;
   logic [2:0]       r_rgb;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk        (clk),
      .reset      (reset),
      .o_line_end (w_line_end),
      .o_hsync_on (w_hsync_on),
      .o_vsync_on (w_vsync_on),
      .o_active   (w_active)
   );

   // Bar index tracks hcount/BAR_WIDTH without a divider: a down-counter
   // reloads every BAR_WIDTH pixels and the whole thing restarts with the line.
   // The index saturates at 7; past the active area it is masked anyway.
   always_ff @(posedge clk) begin
      if (reset || w_line_end) begin
         r_bar      <= '0;
         r_bar_left <= BAR_LAST;
      end else if (r_bar_left == '0) begin
         r_bar_left <= BAR_LAST;
         if (r_bar != 3'd7) begin
            r_bar <= r_bar + 3'd1;
         end
      end else begin
         r_bar_left <= r_bar_left - BAR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hsync <= ~SYNC_POL;
         r_vsync <= ~SYNC_POL;
         r_rgb   <= RGB_BLACK;
      end else begin
         r_hsync <= w_hsync_on ? SYNC_POL : ~SYNC_POL;
         r_vsync <= w_vsync_on ? SYNC_POL : ~SYNC_POL;
         r_rgb   <= w_active ? bar_color(r_bar) : RGB_BLACK;
      end
   end

   assign hsync            = r_hsync;
   assign vsync            = r_vsync;
   assign {red, grn, blu}  = r_rgb;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: default timing (both sync polarities) plus a
// shrunken raster so whole frames fit in a short run.
module tb_vga_controller;
   import vga_pkg::*;

   localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
   localparam int S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 1;
   localparam int S_BW = 2;
   localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
   localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

   typedef struct {
      int         pix;
      logic [4:0] exp;   // {hsync, vsync, red, grn, blu}
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic a_hs, a_vs, a_r, a_g, a_b;
   logic b_hs, b_vs, b_r, b_g, b_b;
   logic c_hs, c_vs, c_r, c_g, c_b;

   int   n_pass  = 0;
   int   n_total = 0;
   int   cnt     = 0;
   int   a_last_rise = -1;
   int   a_high      = 0;
   logic a_prev_hs   = 1'b0;
   int   c_last_rise = -1;
   int   c_high      = 0;
   logic c_prev_vs   = 1'b0;
   vec_t tbl[18];

   always #5 clk = ~clk;

   vga_controller u_a (
      .clk(clk), .reset(reset), .hsync(a_hs), .vsync(a_vs), .red(a_r), .grn(a_g), .blu(a_b));

   vga_controller #(.SYNC_POL(1'b0)) u_b (
      .clk(clk), .reset(reset), .hsync(b_hs), .vsync(b_vs), .red(b_r), .grn(b_g), .blu(b_b));

   vga_controller #(
      .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
      .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
      .SYNC_POL(1'b1), .BAR_WIDTH(S_BW)
   ) u_c (
      .clk(clk), .reset(reset), .hsync(c_hs), .vsync(c_vs), .red(c_r), .grn(c_g), .blu(c_b));

   // Reference: n clocks after reset release the pins show raster pixel n-1,
   // located by plain division of the pixel index by the line/frame sizes.
   function automatic logic [4:0] model(input int n, input int ha, input int hf, input int hs,
                                        input int hb, input int va, input int vf, input int vs,
                                        input int vb, input int bw, input logic pol);
      int ht, vt, p, h, v;
      logic hsy, vsy;
      logic [2:0] rgb;
      if (n == 0) return {~pol, ~pol, 3'b000};
      ht  = ha + hf + hs + hb;
      vt  = va + vf + vs + vb;
      p   = n - 1;
      h   = p % ht;
      v   = (p / ht) % vt;
      hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
      vsy = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
      rgb = (h < ha && v < va) ? 3'(7 - h / bw) : 3'b000;
      return {hsy, vsy, rgb};
   endfunction

   task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cnt=%0d actual=%b required=%b", name, cnt, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s cnt=%0d actual=%0d required=%0d", name, cnt, act, exp);
   endtask

   task automatic step();
      logic was_reset;
      was_reset = reset;
      @(posedge clk);
      #1;
      cnt = was_reset ? 0 : cnt + 1;
      check5("dutA_px", {a_hs, a_vs, a_r, a_g, a_b},
             model(cnt, DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                   DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP, DEF_BAR_WIDTH, 1'b1));
      check5("dutB_neg_px", {b_hs, b_vs, b_r, b_g, b_b},
             model(cnt, DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                   DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP, DEF_BAR_WIDTH, 1'b0));
      check5("dutC_small_px", {c_hs, c_vs, c_r, c_g, c_b},
             model(cnt, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_BW, 1'b1));
      if (was_reset) begin
         a_last_rise = -1;
         a_high      = 0;
         c_last_rise = -1;
         c_high      = 0;
      end else begin
         if (a_hs && !a_prev_hs) begin
            if (a_last_rise >= 0) check_int("hsync_period", cnt - a_last_rise, DEF_H_TOTAL);
            a_last_rise = cnt;
         end
         if (a_hs) a_high++;
         else if (a_prev_hs) begin
            check_int("hsync_width", a_high, DEF_H_SYNC);
            a_high = 0;
         end
         if (c_vs && !c_prev_vs) begin
            if (c_last_rise >= 0) check_int("vsync_frame_len", cnt - c_last_rise, S_HT * S_VT);
            c_last_rise = cnt;
         end
         if (c_vs) c_high++;
         else if (c_prev_vs) begin
            check_int("vsync_width", c_high, S_VS * S_HT);
            c_high = 0;
         end
      end
      a_prev_hs = a_hs;
      c_prev_vs = c_vs;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cnt=%0d actual=timeout required=finish", cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      tbl[0]  = '{0,    5'b00111};
      tbl[1]  = '{99,   5'b00111};
      tbl[2]  = '{100,  5'b00110};
      tbl[3]  = '{199,  5'b00110};
      tbl[4]  = '{200,  5'b00101};
      tbl[5]  = '{350,  5'b00100};
      tbl[6]  = '{450,  5'b00011};
      tbl[7]  = '{599,  5'b00010};
      tbl[8]  = '{600,  5'b00001};
      tbl[9]  = '{799,  5'b00000};
      tbl[10] = '{800,  5'b00000};
      tbl[11] = '{839,  5'b00000};
      tbl[12] = '{840,  5'b10000};
      tbl[13] = '{967,  5'b10000};
      tbl[14] = '{968,  5'b00000};
      tbl[15] = '{1055, 5'b00000};
      tbl[16] = '{1056, 5'b00111};
      tbl[17] = '{1896, 5'b10000};

      reset = 1'b1;
      repeat (3) step();
      check5("reset_outputs", {a_hs, a_vs, a_r, a_g, a_b}, 5'b00000);
      reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         guard = 0;
         while (cnt - 1 < tbl[i].pix && guard < 5000) begin
            step();
            guard++;
         end
         check5($sformatf("tbl%0d_pix%0d", i, tbl[i].pix), {a_hs, a_vs, a_r, a_g, a_b}, tbl[i].exp);
      end

      // One-clock reset in the middle of line 2, pixel 500.
      guard = 0;
      while (cnt - 1 < 2 * DEF_H_TOTAL + 500 && guard < 5000) begin
         step();
         guard++;
      end
      reset = 1'b1;
      step();
      check5("midline_reset_outputs", {a_hs, a_vs, a_r, a_g, a_b}, 5'b00000);
      check5("midline_reset_neg", {b_hs, b_vs, b_r, b_g, b_b}, 5'b11000);
      reset = 1'b0;
      step();
      check5("restart_white", {a_hs, a_vs, a_r, a_g, a_b}, 5'b00111);
      guard = 0;
      while (!a_hs && guard < 2000) begin
         step();
         guard++;
      end
      check_int("restart_hsync_pixel", cnt - 1, DEF_H_ACTIVE + DEF_H_FP);

      // Random reset pulses at arbitrary raster positions.
      for (int k = 0; k < 12; k++) begin
         repeat ($urandom_range(2500, 50)) step();
         reset = 1'b1;
         repeat ($urandom_range(3, 1)) step();
         reset = 1'b0;
      end
      repeat (1200) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
